// File: rtl/mouse_display_pkg.sv
// -----------------------------------------------------------------------------
// mouse_display_pkg
// Shared types and constants for the mouse coordinate digit formatter and its
// sequential binary-to-BCD engine.
//   fmt_state_e    : formatter FSM encoding (IDLE -> CONV -> COMMIT)
//   DATA_W         : coordinate width (only 8 is supported)
//   BCD_DIGITS     : decimal digits produced (255 max needs three)
//   NIBBLE_W       : width of one digit
//   ADD3_THRESHOLD : double-dabble correction threshold
//   ITER_COUNT     : shift iterations per conversion (one per input bit)
//   add3_nibble()  : double-dabble per-digit correction
// -----------------------------------------------------------------------------
package mouse_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } fmt_state_e;

  localparam int DATA_W         = 8;
  localparam int BCD_DIGITS     = 3;
  localparam int NIBBLE_W       = 4;
  localparam int ADD3_THRESHOLD = 5;
  localparam int ITER_COUNT     = DATA_W;

  // A digit of 5..9 would become >= 10 after the next doubling, so pre-add 3
  // to make the shift carry into the next digit instead.
  function automatic logic [NIBBLE_W-1:0] add3_nibble(input logic [NIBBLE_W-1:0] n);
    if (n >= NIBBLE_W'(ADD3_THRESHOLD)) begin
      return n + NIBBLE_W'(3);
    end
    return n;
  endfunction

endpackage

// File: rtl/mouse_digit_formatter_if.sv
// -----------------------------------------------------------------------------
// mouse_digit_formatter_if
// Bundles the coordinate inputs, mode controls and digit outputs of the
// formatter.
//   master : coordinate source / display side (drives X/Y, UPDATE, modes;
//            reads digits and BUSY)
//   slave  : the formatter itself
// Signals:
//   MOUSE_X, MOUSE_Y : current coordinates
//   UPDATE           : one-cycle strobe, new coordinates available
//   DEC_MODE         : 0 = hex both axes, 1 = decimal single axis
//   AXIS_SEL         : decimal axis select, 0 = X, 1 = Y
//   NUM0..NUM3       : digits, NUM0 rightmost
//   BUSY             : decimal conversion in progress
// -----------------------------------------------------------------------------
interface mouse_digit_formatter_if;
  import mouse_display_pkg::*;

  logic [DATA_W-1:0]   MOUSE_X;
  logic [DATA_W-1:0]   MOUSE_Y;
  logic                UPDATE;
  logic                DEC_MODE;
  logic                AXIS_SEL;
  logic [NIBBLE_W-1:0] NUM0;
  logic [NIBBLE_W-1:0] NUM1;
  logic [NIBBLE_W-1:0] NUM2;
  logic [NIBBLE_W-1:0] NUM3;
  logic                BUSY;

  modport master (
    output MOUSE_X, MOUSE_Y, UPDATE, DEC_MODE, AXIS_SEL,
    input  NUM0, NUM1, NUM2, NUM3, BUSY
  );

  modport slave (
    input  MOUSE_X, MOUSE_Y, UPDATE, DEC_MODE, AXIS_SEL,
    output NUM0, NUM1, NUM2, NUM3, BUSY
  );

endinterface

// File: rtl/mouse_digit_formatter_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential shift/add-3 (double dabble) binary-to-BCD converter, one bit per
// clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load value and begin a conversion (ignored result-wise if a
//                conversion is already running: it restarts)
//   value      : binary input, sampled on the start edge
//   done       : high during the final iteration cycle; the digit outputs
//                hold the finished result from the following edge onward
//   bcd_ones, bcd_tens, bcd_hund : BCD digits
// -----------------------------------------------------------------------------
module bin2bcd_seq
  import mouse_display_pkg::*;
#(
  parameter int VALUE_W = DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [VALUE_W-1:0]  value,
  output logic                done,
  output logic [NIBBLE_W-1:0] bcd_ones,
  output logic [NIBBLE_W-1:0] bcd_tens,
  output logic [NIBBLE_W-1:0] bcd_hund
);

  localparam int BCD_W   = BCD_DIGITS * NIBBLE_W;
  localparam int SHREG_W = BCD_W + VALUE_W;
  localparam int CNT_W   = $clog2(ITER_COUNT + 1);

  // Layout: {hundreds, tens, ones, binary}; the binary part drains into the
  // BCD part one bit per shift.
  logic [SHREG_W-1:0] shreg_reg, shreg_next;
  logic [SHREG_W-1:0] adjusted;
  logic [CNT_W-1:0]   iter_cnt_reg, iter_cnt_next;
  logic               running_reg, running_next;

  assign adjusted[VALUE_W-1:0] = shreg_reg[VALUE_W-1:0];

  generate
    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_add3
      assign adjusted[VALUE_W + gi*NIBBLE_W +: NIBBLE_W] =
        add3_nibble(shreg_reg[VALUE_W + gi*NIBBLE_W +: NIBBLE_W]);
    end
  endgenerate

  always_comb begin
    shreg_next    = shreg_reg;
    iter_cnt_next = iter_cnt_reg;
    running_next  = running_reg;
    if (start) begin
      shreg_next    = {{BCD_W{1'b0}}, value};
      iter_cnt_next = '0;
      running_next  = 1'b1;
    end else if (running_reg) begin
      shreg_next    = {adjusted[SHREG_W-2:0], 1'b0};
      iter_cnt_next = iter_cnt_reg + CNT_W'(1);
      if (iter_cnt_reg == CNT_W'(ITER_COUNT - 1)) begin
        running_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_reg    <= '0;
      iter_cnt_reg <= '0;
      running_reg  <= 1'b0;
    end else begin
      shreg_reg    <= shreg_next;
      iter_cnt_reg <= iter_cnt_next;
      running_reg  <= running_next;
    end
  end

  assign done     = running_reg && (iter_cnt_reg == CNT_W'(ITER_COUNT - 1));
  assign bcd_ones = shreg_reg[VALUE_W              +: NIBBLE_W];
  assign bcd_tens = shreg_reg[VALUE_W + NIBBLE_W   +: NIBBLE_W];
  assign bcd_hund = shreg_reg[VALUE_W + 2*NIBBLE_W +: NIBBLE_W];

endmodule

// File: rtl/mouse_digit_formatter.sv
// -----------------------------------------------------------------------------
// mouse_digit_formatter
// Turns the latest mouse coordinates into four display digits.
//   Hex mode     : NUM3..NUM0 = Y[7:4], Y[3:0], X[7:4], X[3:0], committed on
//                  the start edge itself.
//   Decimal mode : NUM3 = selected axis (0/1), NUM2..NUM0 = hundreds, tens,
//                  ones of that axis, committed nine edges after start.
// A holdoff counter throttles commits; UPDATEs that cannot start immediately
// are remembered in a pending flag and served with the coordinates present
// when the start finally happens.
// Ports:
//   CLK   : system clock
//   RESET : asynchronous active-low reset
//   bus   : mouse_digit_formatter_if.slave (coordinates, modes, digits, BUSY)
// Parameters:
//   HOLDOFF_MAX : minimum cycles between commits
//   DATA_WIDTH  : coordinate width, 8 only
// -----------------------------------------------------------------------------
module mouse_digit_formatter
  import mouse_display_pkg::*;
#(
  parameter int HOLDOFF_MAX = 9_999_999,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                     CLK,
  input  logic                     RESET,
  mouse_digit_formatter_if.slave   bus
);

  localparam int HOLD_W = (HOLDOFF_MAX < 1) ? 1 : $clog2(HOLDOFF_MAX + 1);

  fmt_state_e          state_reg, state_next;
  logic                pending_reg, pending_next;
  logic [HOLD_W-1:0]   holdoff_reg, holdoff_next;
  logic                axis_reg, axis_next;
  logic [NIBBLE_W-1:0] num0_reg, num0_next;
  logic [NIBBLE_W-1:0] num1_reg, num1_next;
  logic [NIBBLE_W-1:0] num2_reg, num2_next;
  logic [NIBBLE_W-1:0] num3_reg, num3_next;

  logic                start;
  logic                dec_start;
  logic [DATA_WIDTH-1:0] sel_value;
  logic                conv_done;
  logic [NIBBLE_W-1:0] bcd_ones, bcd_tens, bcd_hund;

  assign start     = (state_reg == ST_IDLE) && (bus.UPDATE || pending_reg) &&
                     (holdoff_reg == '0);
  assign dec_start = start && bus.DEC_MODE;
  assign sel_value = bus.AXIS_SEL ? bus.MOUSE_Y : bus.MOUSE_X;

  bin2bcd_seq #(
    .VALUE_W (DATA_WIDTH)
  ) u_bin2bcd (
    .clk      (CLK),
    .rst_n    (RESET),
    .start    (dec_start),
    .value    (sel_value),
    .done     (conv_done),
    .bcd_ones (bcd_ones),
    .bcd_tens (bcd_tens),
    .bcd_hund (bcd_hund)
  );

  always_comb begin
    state_next   = state_reg;
    axis_next    = axis_reg;
    num0_next    = num0_reg;
    num1_next    = num1_reg;
    num2_next    = num2_reg;
    num3_next    = num3_reg;
    holdoff_next = (holdoff_reg == '0) ? '0 : holdoff_reg - HOLD_W'(1);

    // Any UPDATE that does not start a refresh (busy, holdoff, or landing on
    // the commit edge) is remembered.
    if (start) begin
      pending_next = 1'b0;
    end else if (bus.UPDATE) begin
      pending_next = 1'b1;
    end else begin
      pending_next = pending_reg;
    end

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (bus.DEC_MODE) begin
            axis_next  = bus.AXIS_SEL;
            state_next = ST_CONV;
          end else begin
            num0_next    = bus.MOUSE_X[3:0];
            num1_next    = bus.MOUSE_X[7:4];
            num2_next    = bus.MOUSE_Y[3:0];
            num3_next    = bus.MOUSE_Y[7:4];
            holdoff_next = HOLD_W'(HOLDOFF_MAX);
          end
        end
      end
      ST_CONV: begin
        if (conv_done) begin
          state_next = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        num0_next    = bcd_ones;
        num1_next    = bcd_tens;
        num2_next    = bcd_hund;
        num3_next    = {3'b000, axis_reg};
        holdoff_next = HOLD_W'(HOLDOFF_MAX);
        state_next   = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg   <= ST_IDLE;
      pending_reg <= 1'b0;
      holdoff_reg <= '0;
      axis_reg    <= 1'b0;
      num0_reg    <= '0;
      num1_reg    <= '0;
      num2_reg    <= '0;
      num3_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      holdoff_reg <= holdoff_next;
      axis_reg    <= axis_next;
      num0_reg    <= num0_next;
      num1_reg    <= num1_next;
      num2_reg    <= num2_next;
      num3_reg    <= num3_next;
    end
  end

  assign bus.NUM0 = num0_reg;
  assign bus.NUM1 = num1_reg;
  assign bus.NUM2 = num2_reg;
  assign bus.NUM3 = num3_reg;
  assign bus.BUSY = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mouse_digit_formatter.sv
// -----------------------------------------------------------------------------
// tb_mouse_digit_formatter
// Directed bench for mouse_digit_formatter with HOLDOFF_MAX = 4. Inputs change
// 1 ns after a rising edge; outputs are sampled at the same point, so the
// value seen after edge En is the state committed at En.
// -----------------------------------------------------------------------------
module tb_mouse_digit_formatter;

  logic clk;
  logic rst_n;
  int   vec_cnt;
  int   miscompare_cnt;

  mouse_digit_formatter_if bus();

  mouse_digit_formatter #(
    .HOLDOFF_MAX (4),
    .DATA_WIDTH  (8)
  ) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] digits();
    return {bus.NUM3, bus.NUM2, bus.NUM1, bus.NUM0};
  endfunction

  task automatic check_value(input string tag, input logic [15:0] got,
                             input logic [15:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompare_cnt++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse UPDATE so that the next rising edge (E0) samples it; returns just
  // after E0.
  task automatic pulse_update();
    bus.UPDATE = 1'b1;
    tick();
    bus.UPDATE = 1'b0;
  endtask

  task automatic show(input string what);
    $display("[%0t] %s: NUM3..0=%h BUSY=%b", $time, what, digits(), bus.BUSY);
  endtask

  initial begin
    vec_cnt        = 0;
    miscompare_cnt = 0;
    rst_n          = 1'b0;
    bus.MOUSE_X    = '0;
    bus.MOUSE_Y    = '0;
    bus.UPDATE     = 1'b0;
    bus.DEC_MODE   = 1'b0;
    bus.AXIS_SEL   = 1'b0;

    // Reset state
    tick(3);
    check_value("reset_digits", digits(), 16'h0000);
    check_value("reset_busy", {15'd0, bus.BUSY}, 16'd0);
    show("reset");
    rst_n = 1'b1;
    tick(2);

    // Hex mode: one-edge latency, BUSY never rises
    bus.MOUSE_X = 8'hA7;
    bus.MOUSE_Y = 8'h3C;
    pulse_update();
    check_value("hex_digits", digits(), 16'h3CA7);
    check_value("hex_busy", {15'd0, bus.BUSY}, 16'd0);
    show("hex A7/3C");
    tick(6);

    // Decimal X = 255: BUSY over E0..E8, digits held until E9
    bus.DEC_MODE = 1'b1;
    bus.AXIS_SEL = 1'b0;
    bus.MOUSE_X  = 8'd255;
    pulse_update();
    check_value("dec255_busy_e0", {15'd0, bus.BUSY}, 16'd1);
    for (int e = 1; e <= 8; e++) begin
      tick();
      check_value("dec255_busy_conv", {15'd0, bus.BUSY}, 16'd1);
    end
    check_value("dec255_hold_e8", digits(), 16'h3CA7);
    tick();
    check_value("dec255_digits", digits(), 16'h0255);
    check_value("dec255_busy_e9", {15'd0, bus.BUSY}, 16'd0);
    show("dec X=255");
    tick(6);

    // Decimal Y axis: 0 then 109
    bus.AXIS_SEL = 1'b1;
    bus.MOUSE_Y  = 8'd0;
    pulse_update();
    tick(9);
    check_value("decY0_digits", digits(), 16'h1000);
    show("dec Y=0");
    tick(6);
    bus.MOUSE_Y = 8'd109;
    pulse_update();
    tick(9);
    check_value("decY109_digits", digits(), 16'h1109);
    show("dec Y=109");
    tick(6);

    // Decimal X = 42, second UPDATE at E3 with X = 199 becomes pending
    bus.AXIS_SEL = 1'b0;
    bus.MOUSE_X  = 8'd42;
    pulse_update();              // E0
    tick(2);                     // E1, E2
    bus.MOUSE_X = 8'd199;
    pulse_update();              // E3
    tick(6);                     // E9
    check_value("dec42_digits", digits(), 16'h0042);
    show("dec X=42");
    tick(5);                     // E14: holdoff expired at E13, restart here
    check_value("pend_busy_e14", {15'd0, bus.BUSY}, 16'd1);
    tick(8);                     // E22
    check_value("pend_hold_e22", digits(), 16'h0042);
    tick();                      // E23
    check_value("pend199_digits", digits(), 16'h0199);
    show("dec X=199 (pending)");
    tick(20);
    check_value("no_third_commit", digits(), 16'h0199);
    check_value("no_third_busy", {15'd0, bus.BUSY}, 16'd0);

    // Reset in the middle of converting 128
    bus.MOUSE_X = 8'd128;
    pulse_update();              // E0
    tick(4);                     // E4
    check_value("abort_pre_busy", {15'd0, bus.BUSY}, 16'd1);
    rst_n = 1'b0;
    #1;
    check_value("abort_digits", digits(), 16'h0000);
    check_value("abort_busy", {15'd0, bus.BUSY}, 16'd0);
    tick(2);
    rst_n = 1'b1;
    tick(20);
    check_value("abort_no_commit", digits(), 16'h0000);
    check_value("abort_idle_busy", {15'd0, bus.BUSY}, 16'd0);
    show("abort X=128");

    // Hex back-to-back UPDATEs: second commits five edges after the first
    bus.DEC_MODE = 1'b0;
    bus.MOUSE_X  = 8'h12;
    bus.MOUSE_Y  = 8'h34;
    pulse_update();              // E0
    check_value("b2b_first", digits(), 16'h3412);
    bus.MOUSE_X = 8'h56;
    bus.MOUSE_Y = 8'h78;
    pulse_update();              // E1
    check_value("b2b_hold_e1", digits(), 16'h3412);
    tick(3);                     // E4
    check_value("b2b_hold_e4", digits(), 16'h3412);
    tick();                      // E5
    check_value("b2b_second", digits(), 16'h7856);
    show("hex back-to-back");
    bus.MOUSE_X = 8'h9A;
    tick(10);
    check_value("b2b_no_extra", digits(), 16'h7856);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
    $finish;
  end

endmodule

// File: doc/mouse_digit_formatter.md
Name: mouse_digit_formatter

Overview:
Formats the latest mouse X/Y coordinates into the four 4-bit digit values (NUM0..NUM3) consumed by the seven-segment wrapper. It sits directly upstream of the display wrapper and downstream of the mouse transceiver's coordinate registers and byte-received strobe. It supports a hex mode, which shows both axes, and a decimal mode, which shows one axis via a sequential double-dabble conversion. A holdoff limits the digit refresh rate so the display stays readable.

Parameters:
HOLDOFF_MAX, 9_999_999, minimum cycles between successive digit commits (100 ms at 100 MHz); benches override it with a small value.
DATA_WIDTH, 8, coordinate width; 8 is the only supported value.

Ports:
CLK  input  1  system clock, 100 MHz
RESET  input  1  asynchronous, active-low reset
MOUSE_X  input  8  current X coordinate
MOUSE_Y  input  8  current Y coordinate
UPDATE  input  1  one-cycle strobe: new coordinates available
DEC_MODE  input  1  0 = hex both axes, 1 = decimal single axis
AXIS_SEL  input  1  decimal mode only: 0 = X, 1 = Y
NUM0  output  4  rightmost digit
NUM1  output  4  digit 1
NUM2  output  4  digit 2
NUM3  output  4  leftmost digit
BUSY  output  1  high while a conversion is in progress

Behaviour:
- Reset (RESET low, asynchronous): NUM0..NUM3 = 0, BUSY = 0, pending = 0, holdoff counter = 0, FSM = IDLE. Reset mid-conversion aborts the conversion and leaves no partial result.
- Holdoff counter: loads HOLDOFF_MAX on every commit, decrements by 1 per cycle, saturates at 0. A new start is allowed only when the counter is 0.
- Start condition in IDLE: (UPDATE or pending) and holdoff == 0. At the start edge:
  - MOUSE_X and MOUSE_Y are captured.
  - DEC_MODE and AXIS_SEL are sampled.
  - pending is cleared.
  - Mode and axis are never re-sampled mid-operation.
- UPDATE when no start is possible (BUSY high, or holdoff nonzero): pending is set. Data is not held; the coordinate values at the eventual start edge are used.
- Hex mode, 1-cycle latency. At the start edge (E0) commit directly:
  - NUM0 = X[3:0], NUM1 = X[7:4], NUM2 = Y[3:0], NUM3 = Y[7:4].
  - BUSY stays 0.
- Decimal mode, FSM IDLE -> CONV -> COMMIT -> IDLE:
  - E0: load the shift register with {12'b0, value}, set iteration count to 0, BUSY = 1, go to CONV.
  - E1..E8 (CONV): each cycle, add 3 to every BCD nibble >= 5, then shift the whole register left by 1. The count reaches 8 at E8, then go to COMMIT.
  - E9 (COMMIT): NUM0 = ones, NUM1 = tens, NUM2 = hundreds, NUM3 = {3'b000, axis}. BUSY = 0, load holdoff, go to IDLE.
  - Total latency from the UPDATE-sampling edge to new digits is 9 edges.
- Commits are atomic: all four NUM outputs change on the same edge, and the outputs hold their last committed values otherwise.
- UPDATE coinciding with the COMMIT edge sets pending; the restart occurs once holdoff expires.
- HOLDOFF_MAX = 0: back-to-back starts are allowed on the cycle after commit.
- Maximum decimal value is 255, so hundreds <= 2 and no overflow handling is needed.

Decomposition:
- Shared package mouse_display_pkg:
  - FSM state encoding (IDLE, CONV, COMMIT).
  - BCD_DIGITS = 3 and NIBBLE_W = 4.
  - ADD3_THRESHOLD = 5.
  - Iteration count constant (= DATA_WIDTH).
- One sub-module, bin2bcd_seq: the shift/add-3 engine.
  - Interface: START, value in, DONE pulse, three BCD nibbles.
  - The formatter keeps the mode/pending/holdoff control and the output registers.

Test Plan:
- Reset, then hex mode (HOLDOFF_MAX = 4): X = 8'hA7, Y = 8'h3C, UPDATE pulse -> one edge later NUM3..NUM0 = 3, C, A, 7 and BUSY stays 0.
- Decimal mode, AXIS_SEL = 0, X = 8'd255, UPDATE -> BUSY high for E0..E8; at E9 NUM3..NUM0 = 0, 2, 5, 5; BUSY low.
- Decimal mode, AXIS_SEL = 1, Y = 8'd0 then Y = 8'd109 with UPDATE pulses spaced beyond holdoff -> NUM3..NUM0 = 1, 0, 0, 0, then 1, 1, 0, 9.
- Decimal mode, X = 8'd42 with UPDATE, then a second UPDATE at E3 after X changes to 8'd199 -> first commit shows 0, 0, 4, 2; after holdoff a second conversion commits 0, 1, 9, 9; no third commit occurs.
- Decimal conversion of 8'd128 with RESET asserted low at E5 -> all NUM = 0 and BUSY = 0 immediately; no commit occurs after RESET is released, without a new UPDATE.
- HOLDOFF_MAX = 4, hex mode, UPDATE pulses on two consecutive cycles with different data -> first values commit at once; the second values commit exactly when the holdoff counter reaches 0, i.e. 5 edges after the first commit.
